// File: rtl/flag_register_unit.sv
// Sign/zero/carry flag register plus a DEPTH-entry call/return flag stack.
// Optional macro FLAG_OVERFLOW_EN adds the overflow flag (aluOverflow in, overflow out).
module flag_register_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] aluResult,
  input  logic             aluCarry,
`ifdef FLAG_OVERFLOW_EN
  input  logic             aluOverflow,
`endif
  input  logic             flagWrite,
  input  logic             flagPush,
  input  logic             flagPop,
  output logic             sign,
  output logic             zero,
  output logic             carry,
`ifdef FLAG_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             stackFull,
  output logic             stackEmpty,
  output logic             stackError
);

  localparam int PTR_W = $clog2(DEPTH + 1);
`ifdef FLAG_OVERFLOW_EN
  localparam int ENTRY_W = 4;
`else
  localparam int ENTRY_W = 3;
`endif
  localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] ONE_C   = PTR_W'(1);

  // Flag vector layout, MSB first: {S, Z, C[, V]}
  logic [ENTRY_W-1:0] flags_q, flags_d;
  logic [PTR_W-1:0]   count_q, count_d;
  logic               error_q, error_d;
  logic [ENTRY_W-1:0] stack_q [DEPTH];
  logic [ENTRY_W-1:0] stack_d [DEPTH];

  logic [ENTRY_W-1:0] new_flags_s;
  logic [ENTRY_W-1:0] pop_flags_s;
  logic               push_ok_s;
  logic               pop_ok_s;
  logic               illegal_s;

`ifdef FLAG_OVERFLOW_EN
  assign new_flags_s = {aluResult[WIDTH-1], (aluResult == {WIDTH{1'b0}}), aluCarry, aluOverflow};
`else
  assign new_flags_s = {aluResult[WIDTH-1], (aluResult == {WIDTH{1'b0}}), aluCarry};
`endif

  assign stackFull  = (count_q == DEPTH_C);
  assign stackEmpty = (count_q == {PTR_W{1'b0}});

  // Simultaneous push and pop is rejected as a whole rather than treated as a no-op swap.
  assign push_ok_s = flagPush & ~flagPop & ~stackFull;
  assign pop_ok_s  = flagPop & ~flagPush & ~stackEmpty;
  assign illegal_s = (flagPush | flagPop) & ~push_ok_s & ~pop_ok_s;

  // Top-of-stack read mux: select the entry at count-1.
  always_comb begin
    pop_flags_s = {ENTRY_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      pop_flags_s = pop_flags_s | (stack_q[i] & {ENTRY_W{count_q == PTR_W'(i + 1)}});
    end
  end

  // Stack write: a legal push stores the flags held before this edge at slot count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_ok_s && (count_q == PTR_W'(i))) begin
        stack_d[i] = flags_q;
      end else begin
        stack_d[i] = stack_q[i];
      end
    end
  end

  // Flag register, stack pointer and error pulse next-state.
  always_comb begin
    flags_d = flags_q;
    count_d = count_q;
    error_d = illegal_s;
    if (pop_ok_s) begin
      flags_d = pop_flags_s;
    end else if (flagWrite) begin
      flags_d = new_flags_s;
    end else begin
      flags_d = flags_q;
    end
    if (push_ok_s) begin
      count_d = count_q + ONE_C;
    end else if (pop_ok_s) begin
      count_d = count_q - ONE_C;
    end else begin
      count_d = count_q;
    end
  end

  // Architectural state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= {ENTRY_W{1'b0}};
      count_q <= {PTR_W{1'b0}};
      error_q <= 1'b0;
    end else begin
      flags_q <= flags_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  // Stack storage is not reset; entries above count are never read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      stack_q[i] <= stack_d[i];
    end
  end

  assign sign       = flags_q[ENTRY_W-1];
  assign zero       = flags_q[ENTRY_W-2];
  assign carry      = flags_q[ENTRY_W-3];
`ifdef FLAG_OVERFLOW_EN
  assign overflow   = flags_q[0];
`endif
  assign stackError = error_q;

endmodule

// File: tb/tb_flag_register_unit.sv
// Scoreboard bench for flag_register_unit (WIDTH=32, DEPTH=4); honours FLAG_OVERFLOW_EN.
module tb_flag_register_unit;

  logic        clk;
  logic        rst;
  logic [31:0] aluResult;
  logic        aluCarry;
  logic        aluOverflow;
  logic        flagWrite, flagPush, flagPop;
  logic        sign, zero, carry, ovf_o;
  logic        stackFull, stackEmpty, stackError;

  int checks = 0;
  int errors = 0;

  // Expected {S,Z,C,V,full,empty,err} after each edge
  logic [6:0] sb [$];

  logic [3:0] m_flags;
  int         m_count;
  logic [3:0] m_stack [4];
  logic       m_err;

  flag_register_unit #(.WIDTH(32), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .aluResult  (aluResult),
    .aluCarry   (aluCarry),
`ifdef FLAG_OVERFLOW_EN
    .aluOverflow(aluOverflow),
`endif
    .flagWrite  (flagWrite),
    .flagPush   (flagPush),
    .flagPop    (flagPop),
    .sign       (sign),
    .zero       (zero),
    .carry      (carry),
`ifdef FLAG_OVERFLOW_EN
    .overflow   (ovf_o),
`endif
    .stackFull  (stackFull),
    .stackEmpty (stackEmpty),
    .stackError (stackError)
  );

`ifndef FLAG_OVERFLOW_EN
  assign ovf_o = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] obs();
    return {sign, zero, carry, ovf_o, stackFull, stackEmpty, stackError};
  endfunction

  // Apply one cycle of stimulus, advance the model, queue the expectation, step past the edge.
  task automatic drive(input logic [31:0] res, input logic cy, input logic ov,
                       input logic w, input logic pu, input logic po, input logic r);
    logic push_ok, pop_ok;
    logic [3:0] derived;
    aluResult = res; aluCarry = cy; aluOverflow = ov;
    flagWrite = w; flagPush = pu; flagPop = po; rst = r;
`ifdef FLAG_OVERFLOW_EN
    derived = {res[31], (res == 32'd0), cy, ov};
`else
    derived = {res[31], (res == 32'd0), cy, 1'b0};
`endif
    if (r) begin
      m_flags = 4'd0; m_count = 0; m_err = 1'b0;
    end else begin
      push_ok = pu && !po && (m_count < 4);
      pop_ok  = po && !pu && (m_count > 0);
      m_err   = (pu || po) && !push_ok && !pop_ok;
      if (push_ok) begin
        m_stack[m_count] = m_flags;
        m_count++;
      end
      if (pop_ok) begin
        m_flags = m_stack[m_count-1];
        m_count--;
      end else if (w) begin
        m_flags = derived;
      end
    end
    sb.push_back({m_flags, (m_count == 4), (m_count == 0), m_err});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] e;
    for (int k = 0; k < 3; k++) begin
      drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (k < 2) ? 1'b1 : 1'b0);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL reset step %0d: got %b expected %b", k, obs(), e); end
    end
    checks++;
    if (obs() !== 7'b0000010) begin errors++; $display("FAIL reset_state: got %b expected 0000010", obs()); end
  endtask

  task automatic test_derivation();
    logic [6:0] e;
    logic [31:0] v;
    drive(32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL deriv_neg: got %b expected %b", obs(), e); end
    checks++;
    if ({sign, zero, carry} !== 3'b101) begin errors++; $display("FAIL deriv_szc_101: got %b expected 101", {sign, zero, carry}); end
    drive(32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL deriv_zero: got %b expected %b", obs(), e); end
    checks++;
    if ({sign, zero, carry, ovf_o} !== 4'b0100) begin errors++; $display("FAIL deriv_szcv_0100: got %b expected 0100", {sign, zero, carry, ovf_o}); end
    for (int k = 0; k < 8; k++) begin
      v = (k == 3) ? 32'd0 : $urandom;
      drive(v, 1'($urandom), 1'($urandom), (k != 5) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL deriv_rand %0d: got %b expected %b", k, obs(), e); end
    end
  endtask

  task automatic test_push_write();
    logic [6:0] e;
    drive(32'hA000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL pw_setup: got %b expected %b", obs(), e); end
    drive(32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL pw_push: got %b expected %b", obs(), e); end
    checks++;
    if ({sign, zero, carry, stackEmpty} !== 4'b0100) begin errors++; $display("FAIL pw_push_flags: got %b expected 0100", {sign, zero, carry, stackEmpty}); end
    drive(32'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL pw_pop: got %b expected %b", obs(), e); end
    checks++;
    if ({sign, zero, carry, stackEmpty} !== 4'b1011) begin errors++; $display("FAIL pw_pop_flags: got %b expected 1011", {sign, zero, carry, stackEmpty}); end
`ifdef FLAG_OVERFLOW_EN
    checks++;
    if (ovf_o !== 1'b1) begin errors++; $display("FAIL pw_pop_v: got %b expected 1", ovf_o); end
`endif
  endtask

  task automatic test_fill();
    logic [6:0] e;
    for (int k = 0; k < 4; k++) begin
      drive($urandom, 1'($urandom), 1'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL fill_push %0d: got %b expected %b", k, obs(), e); end
    end
    drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL fill_push5: got %b expected %b", obs(), e); end
    checks++;
    if ({stackFull, stackError} !== 2'b11) begin errors++; $display("FAIL fill_overflow_err: got %b expected 11", {stackFull, stackError}); end
    drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL fill_idle: got %b expected %b", obs(), e); end
    checks++;
    if ({stackFull, stackError} !== 2'b10) begin errors++; $display("FAIL fill_err_pulse: got %b expected 10", {stackFull, stackError}); end
    for (int k = 0; k < 4; k++) begin
      drive($urandom, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL fill_pop %0d: got %b expected %b", k, obs(), e); end
    end
    checks++;
    if (stackEmpty !== 1'b1) begin errors++; $display("FAIL fill_empty: got %b expected 1", stackEmpty); end
  endtask

  task automatic test_illegal();
    logic [6:0] e;
    logic [2:0] held;
    drive(32'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL ill_pop_empty: got %b expected %b", obs(), e); end
    checks++;
    if ({sign, zero, carry, stackEmpty, stackError} !== 5'b00111) begin errors++; $display("FAIL ill_pop_empty_hw: got %b expected 00111", {sign, zero, carry, stackEmpty, stackError}); end
    for (int k = 0; k < 2; k++) begin
      drive($urandom, 1'($urandom), 1'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL ill_push %0d: got %b expected %b", k, obs(), e); end
    end
    held = {sign, zero, carry};
    drive(32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL ill_pushpop: got %b expected %b", obs(), e); end
    checks++;
    if ({sign, zero, carry, stackError} !== {held, 1'b1}) begin errors++; $display("FAIL ill_pushpop_hw: got %b expected %b", {sign, zero, carry, stackError}, {held, 1'b1}); end
    for (int k = 0; k < 3; k++) begin
      drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL ill_drain %0d: got %b expected %b", k, obs(), e); end
    end
  endtask

  task automatic test_reset_override();
    logic [6:0] e;
    for (int k = 0; k < 3; k++) begin
      drive(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL rstov_push %0d: got %b expected %b", k, obs(), e); end
    end
    drive(32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL rstov: got %b expected %b", obs(), e); end
    checks++;
    if (obs() !== 7'b0000010) begin errors++; $display("FAIL rstov_state: got %b expected 0000010", obs()); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] e;
    for (int k = 0; k < 80; k++) begin
      drive(($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL b2b %0d: got %b expected %b", k, obs(), e); end
    end
  endtask

  initial begin
    rst = 1'b1; aluResult = 32'd0; aluCarry = 1'b0; aluOverflow = 1'b0;
    flagWrite = 1'b0; flagPush = 1'b0; flagPop = 1'b0;
    m_flags = 4'd0; m_count = 0; m_err = 1'b0;
    test_reset();
    test_derivation();
    test_push_write();
    test_fill();
    test_illegal();
    test_reset_override();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
